// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: in-order queue of predicted branches that resolves the oldest one against execute, trains the predictor and redirects fetch on mispredict.
// Optional BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolution_unit #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fe_valid,
   input  logic [PC_W-1:0]          fe_pc,
   input  logic                     fe_pred_taken,
   input  logic [PC_W-1:0]          fe_pred_target,
   output logic                     fe_ready,
   input  logic                     ex_valid,
   input  logic                     ex_taken,
   input  logic [PC_W-1:0]          ex_target,
   output logic                     resolve,
   output logic                     actual_taken,
   output logic [PC_W-1:0]          resolve_pc,
   output logic                     mispredict,
   output logic [PC_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     underflow_err
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]              stat_branches,
   output logic [31:0]              stat_mispredicts
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [PC_W-1:0] pc_mem [DEPTH];
   logic            pt_mem [DEPTH];
   logic [PC_W-1:0] tg_mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            push, pop, miss;
   logic [PC_W-1:0] head_pc, head_tg;
   logic            head_pt;
   assign fe_ready  = (count < (AW+1)'(DEPTH)) && !mispredict;
   assign pop       = ex_valid && (count != '0);
   assign head_pc   = pc_mem[rd_ptr];
   assign head_pt   = pt_mem[rd_ptr];
   assign head_tg   = tg_mem[rd_ptr];
   // a wrong target only matters when both prediction and outcome are taken
   assign miss      = pop && ((head_pt != ex_taken) || (head_pt && ex_taken && head_tg != ex_target));
   assign push      = fe_valid && fe_ready && !miss;
   assign occupancy = count;
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr] <= fe_pc;
         pt_mem[wr_ptr] <= fe_pred_taken;
         tg_mem[wr_ptr] <= fe_pred_target;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         resolve       <= 1'b0;
         actual_taken  <= 1'b0;
         mispredict    <= 1'b0;
         resolve_pc    <= '0;
         redirect_pc   <= '0;
         underflow_err <= 1'b0;
      end else begin
         resolve      <= pop;
         actual_taken <= pop && ex_taken;
         mispredict   <= miss;
         if (pop) begin
            resolve_pc  <= head_pc;
            redirect_pc <= ex_taken ? ex_target : head_pc + PC_W'(4);
         end
         if (ex_valid && count == '0)
            underflow_err <= 1'b1;
         if (miss) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end
`ifdef BRU_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (pop && stat_branches != '1)
            stat_branches <= stat_branches + 32'd1;
         if (miss && stat_mispredicts != '1)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit: scoreboard bench for branch_resolution_unit.
// A queue model tracks in-flight branches; expected resolve results are queued at drive time and compared when the DUT pulses.
module tb_branch_resolution_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        fe_valid, fe_pred_taken, ex_valid, ex_taken;
   logic [31:0] fe_pc, fe_pred_target, ex_target;
   logic        fe_ready, resolve, actual_taken, mispredict, underflow_err;
   logic [31:0] resolve_pc, redirect_pc;
   logic [2:0]  occupancy;
`ifdef BRU_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif
   typedef struct {logic [31:0] pc; logic pt; logic [31:0] tg;} ent_t;
   typedef struct {logic [31:0] pc; logic tk; logic mis; logic [31:0] red;} exp_t;
   ent_t mq[$];
   exp_t sb[$];
   logic m_mis, m_uf;
   int   n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   branch_resolution_unit #(.DEPTH(4), .PC_W(32)) dut (
      .clk(clk), .reset(reset),
      .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_pred_taken(fe_pred_taken),
      .fe_pred_target(fe_pred_target), .fe_ready(fe_ready),
      .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
      .resolve(resolve), .actual_taken(actual_taken), .resolve_pc(resolve_pc),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .occupancy(occupancy), .underflow_err(underflow_err)
`ifdef BRU_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_mis = 1'b0;
      m_uf  = 1'b0;
   endtask
   task automatic step(input logic fv, input logic [31:0] fpc, input logic fpt, input logic [31:0] ftg,
                       input logic ev, input logic et, input logic [31:0] etg);
      logic rdy, pp, mis;
      ent_t e;
      exp_t x;
      fe_valid = fv; fe_pc = fpc; fe_pred_taken = fpt; fe_pred_target = ftg;
      ex_valid = ev; ex_taken = et; ex_target = etg;
      rdy = (mq.size() < 4) && !m_mis;
      pp  = ev && (mq.size() > 0);
      mis = 1'b0;
      if (pp) begin
         e   = mq.pop_front();
         mis = (e.pt != et) || (e.pt && et && e.tg != etg);
         sb.push_back('{pc: e.pc, tk: et, mis: mis, red: et ? etg : e.pc + 32'd4});
      end
      if (ev && !pp) m_uf = 1'b1;
      if (mis) mq.delete();
      else if (fv && rdy) mq.push_back('{pc: fpc, pt: fpt, tg: ftg});
      m_mis = mis;
      @(posedge clk);
      #1;
      chk("resolve", {31'd0, resolve}, {31'd0, pp});
      if (resolve && sb.size() > 0) begin
         x = sb.pop_front();
         chk("resolve_pc", resolve_pc, x.pc);
         chk("actual_taken", {31'd0, actual_taken}, {31'd0, x.tk});
         chk("mispredict", {31'd0, mispredict}, {31'd0, x.mis});
         if (x.mis) chk("redirect_pc", redirect_pc, x.red);
      end else begin
         chk("actual_taken_idle", {31'd0, actual_taken}, 32'd0);
         chk("mispredict_idle", {31'd0, mispredict}, 32'd0);
      end
      chk("occupancy", {29'd0, occupancy}, mq.size());
      chk("fe_ready", {31'd0, fe_ready}, {31'd0, (mq.size() < 4) && !m_mis});
      chk("underflow_err", {31'd0, underflow_err}, {31'd0, m_uf});
      fe_valid = 1'b0;
      ex_valid = 1'b0;
   endtask
   task automatic push_br(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
      step(1'b1, pc, pt, tg, 1'b0, 1'b0, 32'd0);
   endtask
   task automatic res(input logic et, input logic [31:0] etg);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, et, etg);
   endtask
   task automatic chk_reset_state(input string tag);
      chk({tag, "_occ"}, {29'd0, occupancy}, 32'd0);
      chk({tag, "_ready"}, {31'd0, fe_ready}, 32'd1);
      chk({tag, "_resolve"}, {31'd0, resolve}, 32'd0);
      chk({tag, "_mis"}, {31'd0, mispredict}, 32'd0);
      chk({tag, "_uf"}, {31'd0, underflow_err}, 32'd0);
      chk({tag, "_rpc"}, resolve_pc, 32'd0);
      chk({tag, "_redir"}, redirect_pc, 32'd0);
   endtask
   initial begin
      reset = 1'b1;
      fe_valid = 1'b0; fe_pc = '0; fe_pred_taken = 1'b0; fe_pred_target = '0;
      ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("por");
      reset = 1'b0;
      // async reset with entries queued and a resolve pulse live
      push_br(32'h10, 1'b0, 32'h0);
      push_br(32'h14, 1'b0, 32'h0);
      push_br(32'h18, 1'b0, 32'h0);
      res(1'b0, 32'h0);
      chk("pre_reset_occ", {29'd0, occupancy}, 32'd2);
      #2 reset = 1'b1;
      #1 chk_reset_state("async");
      #1 reset = 1'b0;
      model_reset();
      // correct taken prediction
      push_br(32'h100, 1'b1, 32'h200);
      res(1'b1, 32'h200);
      // direction mispredict flushes younger entries and blocks wrong-path push
      push_br(32'h100, 1'b0, 32'h0);
      push_br(32'h110, 1'b0, 32'h0);
      push_br(32'h120, 1'b0, 32'h0);
      res(1'b1, 32'h400);
      chk("t3_redirect", redirect_pc, 32'h400);
      push_br(32'h130, 1'b0, 32'h0);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      // full queue, dropped push on pop edge, then simultaneous push/pop
      for (int i = 0; i < 5; i++) push_br(32'h40 + 32'(i * 4), 1'b0, 32'h0);
      chk("t4_full", {29'd0, occupancy}, 32'd4);
      step(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t4_pop_drop", {29'd0, occupancy}, 32'd3);
      step(1'b1, 32'h84, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t4_push_pop", {29'd0, occupancy}, 32'd3);
      for (int i = 0; i < 3; i++) res(1'b0, 32'h0);
      // fall-through address wraps
      push_br(32'hFFFF_FFFC, 1'b1, 32'h10);
      res(1'b0, 32'h0);
      chk("t5_wrap", redirect_pc, 32'h0);
      // target mispredict with matching direction
      push_br(32'h300, 1'b1, 32'h500);
      res(1'b1, 32'h504);
      // underflow is sticky
      res(1'b0, 32'h0);
      push_br(32'h200, 1'b0, 32'h0);
      res(1'b0, 32'h0);
      chk("t6_sticky", {31'd0, underflow_err}, 32'd1);
      for (int i = 0; i < 80; i++)
         step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)),
              $urandom_range(0, 1) ? 32'h200 : 32'h300,
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 1) ? 32'h200 : 32'h300);
      #2 reset = 1'b1;
      #1 chk_reset_state("final");
      reset = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
